// File: rtl/iob_wishbone2iob_pkg.sv
// Shared types for the Wishbone-to-IOb bridge: FSM state encoding and its width.
package iob_wishbone2iob_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RDATA = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/iob_wishbone2iob.sv
// Wishbone classic subordinate to IOb native manager bridge, one outstanding transfer.
// Optional request timeout with wb_err_o enabled by defining IOB_WISHBONE2IOB_TIMEOUT_EN.
module iob_wishbone2iob
    import iob_wishbone2iob_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [ADDR_W-1:0]   wb_adr_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                iob_valid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    input  logic                iob_ready_i
);

    state_t state, state_nxt;
    logic   is_read;
    logic   dropped;
    logic   start;
    logic   abort;
    logic   timeout;

    assign start = wb_cyc_i & wb_stb_i;
    // A manager that lets go of the cycle at any point loses the ack, but IOb still finishes.
    assign abort = dropped | ~wb_cyc_i;

`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] tmo_cnt;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            tmo_cnt <= '0;
        end else if (cke_i) begin
            if (state == IDLE) begin
                tmo_cnt <= '0;
            end else if ((state == REQ) && !iob_ready_i) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // Fires on the cycle whose increment would reach all-ones.
    assign timeout = (state == REQ) & ~iob_ready_i & (tmo_cnt == CNT_LAST);
`else
    // Constant 0; TIMEOUT_W only sizes the counter when the timeout is built in.
    assign timeout = (TIMEOUT_W < 0);
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= IDLE;
        end else if (cke_i) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = REQ;
            end
            REQ: begin
                if (iob_ready_i) begin
                    if (is_read)    state_nxt = RDATA;
                    else if (abort) state_nxt = IDLE;
                    else            state_nxt = ACK;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            RDATA: begin
                if (iob_rvalid_i) state_nxt = abort ? IDLE : ACK;
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        iob_valid_o = (state == REQ);
        wb_ack_o    = (state == ACK);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            iob_addr_o  <= '0;
            iob_wdata_o <= '0;
            iob_wstrb_o <= '0;
            is_read     <= 1'b0;
            dropped     <= 1'b0;
            wb_dat_o    <= '0;
            wb_err_o    <= 1'b0;
        end else if (cke_i) begin
            wb_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        iob_addr_o  <= wb_adr_i;
                        iob_wdata_o <= wb_dat_i;
                        iob_wstrb_o <= wb_we_i ? wb_sel_i : '0;
                        is_read     <= ~wb_we_i;
                        dropped     <= 1'b0;
                    end
                end
                REQ: begin
                    if (!wb_cyc_i) dropped <= 1'b1;
                    if (timeout && !abort) wb_err_o <= 1'b1;
                end
                RDATA: begin
                    if (!wb_cyc_i) dropped <= 1'b1;
                    if (iob_rvalid_i && !abort) wb_dat_o <= iob_rdata_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Self-checking bench for iob_wishbone2iob: directed cases plus randomized transfers
// against a byte-lane memory reference model and a separate IOb peripheral model.
module tb_iob_wishbone2iob;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int TIMEOUT_W = 4;

    logic              clk = 1'b0;
    logic              cke;
    logic              arst;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic [ADDR_W-1:0] wb_adr_i;
    logic [3:0]        wb_sel_i;
    logic              wb_we_i;
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_ack_o;
    logic              wb_err_o;
    logic              iob_valid_o;
    logic [ADDR_W-1:0] iob_addr_o;
    logic [DATA_W-1:0] iob_wdata_o;
    logic [3:0]        iob_wstrb_o;
    logic              iob_rvalid_i;
    logic [DATA_W-1:0] iob_rdata_i;
    logic              iob_ready_i;

    iob_wishbone2iob #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk_i       (clk),
        .cke_i       (cke),
        .arst_i      (arst),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_adr_i    (wb_adr_i),
        .wb_sel_i    (wb_sel_i),
        .wb_we_i     (wb_we_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_ack_o    (wb_ack_o),
        .wb_err_o    (wb_err_o),
        .iob_valid_o (iob_valid_o),
        .iob_addr_o  (iob_addr_o),
        .iob_wdata_o (iob_wdata_o),
        .iob_wstrb_o (iob_wstrb_o),
        .iob_rvalid_i(iob_rvalid_i),
        .iob_rdata_i (iob_rdata_i),
        .iob_ready_i (iob_ready_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ref_mem follows the intended Wishbone writes; periph_mem follows what the DUT drives on IOb.
    logic [31:0] ref_mem    [32];
    logic [31:0] periph_mem [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input bit we, input logic [4:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int rdy_dly, input int rv_dly,
                        input bit b2b_in, input bit hold_out, input bit drop);
        int          vcnt, hs_c, hs_n, exp_ack, ack_c;
        bit          acked;
        logic [4:0]  hs_addr;
        logic [31:0] exp_rd;
        vcnt = 0; hs_c = -1; hs_n = 0; ack_c = -1; acked = 0; hs_addr = '0;
        exp_ack = (we ? 2 + rdy_dly : 3 + rdy_dly + rv_dly) + (b2b_in ? 1 : 0);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (sel[i]) ref_mem[adr][i*8 +: 8] = dat[i*8 +: 8];
        end
        exp_rd = ref_mem[adr];
        for (int c = 1; c <= exp_ack + 2 && !acked; c++) begin
            tick();
            iob_ready_i  = 1'b0;
            iob_rvalid_i = 1'b0;
            if (b2b_in && c == 1) chk("b2b_gap_idle", {30'd0, wb_ack_o, iob_valid_o}, 32'd0);
            if (iob_valid_o) begin
                if (vcnt == rdy_dly) begin
                    iob_ready_i = 1'b1;
                    hs_n++;
                    hs_c = c;
                    hs_addr = iob_addr_o;
                    chk("iob_addr", {27'd0, iob_addr_o}, {27'd0, adr});
                    chk("iob_wstrb", {28'd0, iob_wstrb_o}, {28'd0, (we ? sel : 4'b0000)});
                    if (we) chk("iob_wdata", iob_wdata_o, dat);
                    for (int i = 0; i < 4; i++)
                        if (iob_wstrb_o[i]) periph_mem[iob_addr_o][i*8 +: 8] = iob_wdata_o[i*8 +: 8];
                end
                vcnt++;
            end
            if (!we && hs_c >= 0 && c == hs_c + 1 + rv_dly) begin
                iob_rvalid_i = 1'b1;
                iob_rdata_i  = periph_mem[hs_addr];
            end
            if (drop && hs_c >= 0 && c == hs_c + 1) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
            if (wb_ack_o) begin
                acked = 1;
                ack_c = c;
                if (!we) chk("rdata", wb_dat_o, exp_rd);
                chk("err_at_ack", {31'd0, wb_err_o}, 32'd0);
            end
        end
        iob_ready_i  = 1'b0;
        iob_rvalid_i = 1'b0;
        if (drop) chk("drop_no_ack", {31'd0, acked}, 32'd0);
        else      chk("ack_cycle", ack_c, exp_ack);
        chk("handshakes", hs_n, 32'd1);
        if (!hold_out) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
            tick();
            chk("ack_one_cycle", {30'd0, wb_ack_o, iob_valid_o}, 32'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {wb_ack_o, wb_err_o, iob_valid_o, iob_wstrb_o, iob_addr_o}, 32'd0);
        chk({tag, "_data"}, wb_dat_o | iob_wdata_o, 32'd0);
    endtask

    initial begin
        bit hold, prev_hold;
        int vcyc;
        bit seen;
        arst = 1'b1; cke = 1'b1;
        wb_dat_i = '0; wb_adr_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        iob_rvalid_i = 1'b0; iob_rdata_i = '0; iob_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ref_mem[i]    = $urandom;
            periph_mem[i] = ref_mem[i];
        end
        ref_mem[5] = 32'h60; periph_mem[5] = 32'h60;
        tick(); tick();
        chk_reset_outputs("reset");
        arst = 1'b0;
        tick();

        xfer(1'b1, 5'h03, 32'h83, 4'b0001, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("wr_byte_lane", periph_mem[3], ref_mem[3]);
        xfer(1'b0, 5'h05, 32'h0, 4'hF, 3, 1, 1'b0, 1'b0, 1'b0);

        // Back-to-back write then read with cyc/stb held across the ack.
        xfer(1'b1, 5'h09, 32'hA5A5_1234, 4'b1010, 0, 0, 1'b0, 1'b1, 1'b0);
        xfer(1'b0, 5'h09, 32'h0, 4'h0, 0, 0, 1'b1, 1'b0, 1'b0);

        // Manager abandons the read while the data phase is pending.
        xfer(1'b0, 5'h02, 32'h0, 4'hF, 1, 2, 1'b0, 1'b0, 1'b1);
        xfer(1'b1, 5'h02, 32'hCAFE_F00D, 4'hF, 0, 0, 1'b0, 1'b0, 1'b0);

        // Clock enable low freezes REQ even with ready presented.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 5'h0C; wb_dat_i = 32'h1357_9BDF; wb_sel_i = 4'hF;
        tick();
        chk("cke_req_valid", {31'd0, iob_valid_o}, 32'd1);
        cke = 1'b0; iob_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cke_frozen", {30'd0, iob_valid_o, wb_ack_o}, 32'd2);
        end
        cke = 1'b1;
        tick();
        iob_ready_i = 1'b0;
        chk("cke_resume_ack", {30'd0, iob_valid_o, wb_ack_o}, 32'd1);
        ref_mem[12] = 32'h1357_9BDF; periph_mem[12] = 32'h1357_9BDF;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();

        // Asynchronous reset while a request is outstanding.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 5'h07; wb_dat_i = 32'hDEAD_BEEF; wb_sel_i = 4'hF;
        tick();
        chk("rst_pre_valid", {31'd0, iob_valid_o}, 32'd1);
        arst = 1'b1;
        tick();
        chk_reset_outputs("rst_mid");
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        arst = 1'b0;
        tick();
        xfer(1'b1, 5'h07, 32'h0BAD_F00D, 4'b0110, 1, 0, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 5'h07, 32'h0, 4'h0, 0, 0, 1'b0, 1'b0, 1'b0);

`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 5'h11; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
        vcyc = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (wb_err_o) begin
                seen = 1;
                chk("tmo_valid_low", {30'd0, iob_valid_o, wb_ack_o}, 32'd0);
            end else if (iob_valid_o) begin
                vcyc++;
            end
        end
        chk("tmo_err_seen", {31'd0, seen}, 32'd1);
        chk("tmo_req_cycles", vcyc, 32'd15);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
        chk("tmo_err_one_cycle", {31'd0, wb_err_o}, 32'd0);
`endif

        prev_hold = 0;
        for (int n = 0; n < 24; n++) begin
            hold = (n != 23) && ($urandom_range(0, 2) == 0);
            xfer(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                 prev_hold, hold, 1'b0);
            prev_hold = hold;
        end
        for (int i = 0; i < 32; i++) begin
            if (periph_mem[i] !== ref_mem[i]) chk("mem_final", periph_mem[i], ref_mem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
